// File: rtl/cordic_sequencer_pkg.sv
// Shared constants for the CORDIC iteration sequencer: state encoding,
// mode values and the default iteration parameters.
package cordic_sequencer_pkg;

  localparam int DEF_ITERATIONS      = 16;
  localparam int DEF_ITERATION_WIDTH = 5;

  localparam logic MODE_VECTORING = 1'b0;
  localparam logic MODE_ROTATION  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_FINAL   = 2'd3
  } state_t;

endpackage

// File: rtl/cordic_sequencer_if.sv
// Control/status bundle between the CORDIC sequencer and its requester/datapath.
interface cordic_sequencer_if #(
  parameter int ITERATION_WIDTH = 5
);
  logic                       start;
  logic                       mode;
  logic [ITERATION_WIDTH-1:0] n_iter;
  logic                       abort;
  logic                       y_neg;
  logic                       z_neg;
  logic                       done;
  logic                       busy;
  logic                       load;
  logic                       iter_en;
  logic [ITERATION_WIDTH-1:0] iter_idx;
  logic                       dir;
  logic                       mode_q;
  logic                       valid;

  modport master (
    output start, mode, n_iter, abort, y_neg, z_neg,
    input  done, busy, load, iter_en, iter_idx, dir, mode_q, valid
  );

  modport slave (
    input  start, mode, n_iter, abort, y_neg, z_neg,
    output done, busy, load, iter_en, iter_idx, dir, mode_q, valid
  );
endinterface

// File: rtl/cordic_iter_counter.sv
// Loadable, clearable up-counter; at_term flags count == term.
module cordic_iter_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         at_term
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      count <= '0;
    else if (clr)  count <= '0;
    else if (ld)   count <= ld_val;
    else if (en)   count <= count + W'(1);
  end

  assign at_term = (count == term);

endmodule

// File: rtl/cordic_sequencer.sv
// CORDIC micro-rotation sequencer: LOAD strobe, N COMPUTE cycles with
// shift index and rotation direction, then a one-cycle FINAL/valid.
module cordic_sequencer
  import cordic_sequencer_pkg::*;
#(
  parameter int ITERATIONS      = DEF_ITERATIONS,
  parameter int ITERATION_WIDTH = DEF_ITERATION_WIDTH
) (
  input logic             clk,
  input logic             rst,
  cordic_sequencer_if.slave bus
);

  localparam logic [ITERATION_WIDTH-1:0] ITER_MAX = ITERATION_WIDTH'(ITERATIONS);

  state_t                     state;
  logic                       mode_r;
  logic [ITERATION_WIDTH-1:0] cnt_q;
  logic [ITERATION_WIDTH-1:0] eff_cnt;
  logic [ITERATION_WIDTH-1:0] idx;
  logic                       at_term;
  logic                       busy_st;

  // Zero or out-of-range requests fall back to the full iteration count.
  assign eff_cnt = (bus.n_iter == '0 || bus.n_iter > ITER_MAX) ? ITER_MAX : bus.n_iter;
  assign busy_st = (state == ST_LOAD) || (state == ST_COMPUTE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      mode_r <= MODE_VECTORING;
      cnt_q  <= ITER_MAX;
    end else begin
      case (state)
        ST_IDLE: if (bus.start) begin
          state  <= ST_LOAD;
          mode_r <= bus.mode;
          cnt_q  <= eff_cnt;
        end
        ST_LOAD:    state <= bus.abort ? ST_IDLE : ST_COMPUTE;
        ST_COMPUTE: begin
          if (bus.abort)    state <= ST_IDLE;
          else if (at_term) state <= ST_FINAL;
        end
        ST_FINAL:   state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Index holds through FINAL and is cleared on the way back to IDLE.
  cordic_iter_counter #(.W(ITERATION_WIDTH)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     ((busy_st && bus.abort) || state == ST_FINAL),
    .ld      (state == ST_LOAD),
    .ld_val  ('0),
    .en      (state == ST_COMPUTE && !at_term),
    .term    (cnt_q - ITERATION_WIDTH'(1)),
    .count   (idx),
    .at_term (at_term)
  );

  assign bus.done     = (state == ST_IDLE) || (state == ST_FINAL);
  assign bus.busy     = busy_st;
  assign bus.load     = (state == ST_LOAD);
  assign bus.iter_en  = (state == ST_COMPUTE);
  assign bus.valid    = (state == ST_FINAL);
  assign bus.iter_idx = idx;
  assign bus.mode_q   = mode_r;
  assign bus.dir      = (state != ST_COMPUTE) ? 1'b0 :
                        (mode_r == MODE_ROTATION) ? ~bus.z_neg : bus.y_neg;

endmodule

// File: tb/tb_cordic_sequencer.sv
// Directed bench for cordic_sequencer: table of operations plus hand-written
// abort, back-to-back and reset sequences.
module tb_cordic_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   asserts = 0;
  int   fails   = 0;

  cordic_sequencer_if #(.ITERATION_WIDTH(5)) bus ();

  cordic_sequencer #(.ITERATIONS(16), .ITERATION_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] n;
    logic       m;
    int         exp_n;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input int act, input int exp);
    asserts++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Issue one operation and follow it through to IDLE, checking every cycle.
  task automatic run_op(input string nm, input logic [4:0] n, input logic m, input int exp_n);
    int  iters = 0;
    bit  got = 0;
    bit  idx_ok = 1;
    bit  dir_ok = 1;
    logic exp_dir;
    bus.start = 1'b1; bus.mode = m; bus.n_iter = n;
    step();
    bus.start = 1'b0; bus.mode = ~m; bus.n_iter = 5'd3;
    chk({nm, " load"}, bus.load, 1);
    chk({nm, " busy"}, bus.busy, 1);
    for (int k = 1; k <= 40 && !got; k++) begin
      step();
      bus.y_neg = k[0]; bus.z_neg = k[1];
      #1;
      if (bus.iter_en) begin
        if (bus.iter_idx != 5'(iters)) idx_ok = 0;
        exp_dir = m ? ~k[1] : k[0];
        if (bus.dir != exp_dir) dir_ok = 0;
        iters++;
      end
      if (bus.valid) begin
        got = 1;
        chk({nm, " latency"}, k, exp_n + 1);
        chk({nm, " iters"}, iters, exp_n);
        chk({nm, " mode_q"}, bus.mode_q, m);
        chk({nm, " done_final"}, bus.done, 1);
        chk({nm, " idx_final"}, bus.iter_idx, exp_n - 1);
      end
    end
    if (!got) chk({nm, " valid_timeout"}, 0, 1);
    chk({nm, " idx_seq"}, idx_ok, 1);
    chk({nm, " dir_seq"}, dir_ok, 1);
    step();
    chk({nm, " idle_done"}, bus.done, 1);
    chk({nm, " idle_valid"}, bus.valid, 0);
    chk({nm, " idle_idx"}, bus.iter_idx, 0);
  endtask

  // Step into COMPUTE until iter_idx reaches target; returns 1 if found.
  task automatic run_to_idx(input int target, output bit found);
    found = 0;
    bus.start = 1'b1; bus.mode = 1'b0; bus.n_iter = 5'd0;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step();
      if (bus.iter_en && bus.iter_idx == 5'(target)) found = 1;
    end
  endtask

  initial begin
    bit found;
    bit seen;
    bus.start = 0; bus.mode = 0; bus.n_iter = 0; bus.abort = 0;
    bus.y_neg = 0; bus.z_neg = 0;

    vecs[0] = '{5'd0,  1'b0, 16};
    vecs[1] = '{5'd4,  1'b1, 4};
    vecs[2] = '{5'd20, 1'b0, 16};
    vecs[3] = '{5'd1,  1'b1, 1};
    vecs[4] = '{5'd16, 1'b0, 16};
    vecs[5] = '{5'd15, 1'b1, 15};
    vecs[6] = '{5'd17, 1'b0, 16};
    vecs[7] = '{5'd2,  1'b0, 2};

    #12;
    chk("rst done", bus.done, 1);
    chk("rst busy", bus.busy, 0);
    chk("rst load", bus.load, 0);
    chk("rst iter_en", bus.iter_en, 0);
    chk("rst valid", bus.valid, 0);
    chk("rst dir", bus.dir, 0);
    chk("rst idx", bus.iter_idx, 0);
    chk("rst mode_q", bus.mode_q, 0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].n, vecs[i].m, vecs[i].exp_n);

    // Rotation with z_neg=1 subtracts.
    bus.z_neg = 1'b1; bus.start = 1'b1; bus.mode = 1'b1; bus.n_iter = 5'd3;
    step(); bus.start = 1'b0;
    step();
    chk("rot z_neg dir", bus.dir, 0);
    chk("rot iter_en", bus.iter_en, 1);
    for (int k = 0; k < 5; k++) step();
    bus.z_neg = 1'b0;

    // Abort mid-compute.
    run_to_idx(7, found);
    chk("abort reach idx7", found, 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort done", bus.done, 1);
    chk("abort busy", bus.busy, 0);
    chk("abort idx", bus.iter_idx, 0);
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      if (bus.valid) seen = 1;
      step();
    end
    chk("abort no valid", seen, 0);
    run_op("post_abort", 5'd5, 1'b0, 5);

    // Abort during LOAD; abort ignored in IDLE.
    bus.start = 1'b1; bus.abort = 1'b1; bus.n_iter = 5'd4; bus.mode = 1'b1;
    step();
    bus.start = 1'b0;
    chk("abort idle ignored", bus.load, 1);
    step();
    bus.abort = 1'b0;
    chk("abort load idle", bus.done, 1);
    chk("abort load busy", bus.busy, 0);
    step();

    // Start held high throughout: ignored in COMPUTE and at FINAL->IDLE edge.
    bus.start = 1'b1; bus.mode = 1'b1; bus.n_iter = 5'd2;
    step();
    bus.mode = 1'b0; bus.n_iter = 5'd9;
    chk("b2b load", bus.load, 1);
    step(); step();
    chk("b2b mode_q held", bus.mode_q, 1);
    step();
    chk("b2b valid", bus.valid, 1);
    step();
    chk("b2b idle gap", bus.done, 1);
    chk("b2b no load", bus.load, 0);
    step();
    chk("b2b reload", bus.load, 1);
    chk("b2b new mode_q", bus.mode_q, 0);
    bus.start = 1'b0;
    for (int k = 0; k < 12; k++) step();

    // Reset mid-operation.
    run_to_idx(3, found);
    chk("rst reach idx3", found, 1);
    bus.y_neg = 1'b1;
    rst = 1'b0;
    #1;
    chk("mid rst done", bus.done, 1);
    chk("mid rst busy", bus.busy, 0);
    chk("mid rst iter_en", bus.iter_en, 0);
    chk("mid rst dir", bus.dir, 0);
    chk("mid rst idx", bus.iter_idx, 0);
    step();
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      if (bus.valid || bus.busy) seen = 1;
      step();
    end
    chk("mid rst no resume", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
